// File: rtl/nn_node.sv
// nn_node: pipelined neuron computing ReLU(sum(w*x)+bias) saturated to OUTPUT_BITS, latency 3
module nn_node #(
   parameter int N_INPUTS    = 8,
   parameter int WEIGHT_BITS = 5,
   parameter int INPUT_BITS  = 5,
   parameter int SUM_BITS    = 13,
   parameter int OUTPUT_BITS = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic [N_INPUTS*INPUT_BITS-1:0]  inputs,
   input  logic [N_INPUTS*WEIGHT_BITS-1:0] weights,
   input  logic [WEIGHT_BITS-1:0]          bias,
   output logic                            out_valid,
   output logic [OUTPUT_BITS-1:0]          outputs
);
   localparam int PB = INPUT_BITS + WEIGHT_BITS + 1;
   localparam int LV = $clog2(N_INPUTS);
   localparam int P  = 1 << LV;
   localparam logic signed [SUM_BITS-1:0] SAT = SUM_BITS'((1 << OUTPUT_BITS) - 1);
   logic signed [PB-1:0]          prod_d [N_INPUTS];
   logic signed [PB-1:0]          prod_q [N_INPUTS];
   logic signed [WEIGHT_BITS-1:0] bias_d, bias_q;
   logic signed [SUM_BITS-1:0]    sum_d, sum_q, tree_root;
   logic [OUTPUT_BITS-1:0]        out_d, out_q;
   logic [2:0]                    vld_d, vld_q;
   // binary tree padded to a power of two; missing leaves read as zero
   for (genvar l = 0; l <= LV; l++) begin : g_lvl
      logic signed [SUM_BITS-1:0] node [P >> l];
      for (genvar j = 0; j < (P >> l); j++) begin : g_n
         if (l == 0) begin : g_leaf
            if (j < N_INPUTS) begin : g_used
               assign node[j] = SUM_BITS'(prod_q[j]);
            end else begin : g_pad
               assign node[j] = '0;
            end
         end else begin : g_add
            assign node[j] = g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
         end
      end
   end
   assign tree_root = g_lvl[LV].node[0];
   always_comb begin
      for (int k = 0; k < N_INPUTS; k++)
         prod_d[k] = in_valid ? PB'($signed(weights[k*WEIGHT_BITS +: WEIGHT_BITS]))
                              * PB'($signed({1'b0, inputs[k*INPUT_BITS +: INPUT_BITS]})) : prod_q[k];
      bias_d = in_valid ? bias : bias_q;
      sum_d  = vld_q[0] ? tree_root + SUM_BITS'(bias_q) : sum_q;
      out_d  = !vld_q[1] ? out_q :
               (sum_q[SUM_BITS-1] || sum_q == '0) ? '0 :
               (sum_q >= SAT) ? '1 : sum_q[OUTPUT_BITS-1:0];
      vld_d  = {vld_q[1:0], in_valid};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_INPUTS; k++) prod_q[k] <= '0;
         bias_q <= '0;
         sum_q  <= '0;
         out_q  <= '0;
         vld_q  <= '0;
      end else begin
         for (int k = 0; k < N_INPUTS; k++) prod_q[k] <= prod_d[k];
         bias_q <= bias_d;
         sum_q  <= sum_d;
         out_q  <= out_d;
         vld_q  <= vld_d;
      end
   end
   assign out_valid = vld_q[2];
   assign outputs   = out_q;
endmodule

// File: tb/tb_nn_node.sv
// tb_nn_node: table vectors, corner sequences and random traffic against a queue-based reference
module tb_nn_node;
   logic        clk = 0, rst = 0, in_valid = 0;
   logic [39:0] inputs = '0, weights = '0;
   logic [4:0]  bias = '0;
   logic        out_valid;
   logic [7:0]  outputs;
   int checks = 0, errors = 0, cyc = 0, last_o = 0;
   bit armed = 0;
   typedef struct { int due; int val; } exp_t;
   typedef struct { logic [39:0] in; logic [39:0] w; logic [4:0] b; int e; } vec_t;
   exp_t pend[$];
   vec_t tbl[9];
   nn_node dut (.clk(clk), .rst(rst), .in_valid(in_valid), .inputs(inputs), .weights(weights),
                .bias(bias), .out_valid(out_valid), .outputs(outputs));
   always #5 clk = ~clk;
   function automatic int model(logic [39:0] in, logic [39:0] w, logic [4:0] b);
      int s = $signed(b);
      for (int k = 0; k < 8; k++) s += $signed(w[k*5 +: 5]) * int'(in[k*5 +: 5]);
      return s <= 0 ? 0 : s >= 255 ? 255 : s;
   endfunction
   task automatic tick(input logic r, input logic v, input logic [39:0] in, input logic [39:0] w,
                       input logic [4:0] b, input int e);
      bit due;
      exp_t x;
      @(negedge clk);
      if (armed) begin
         due = pend.size() > 0 && pend[0].due == cyc;
         checks++;
         if (out_valid !== due) begin
            errors++;
            $display("FAIL out_valid cyc %0d: got %0b want %0b", cyc, out_valid, due);
         end
         if (due) begin
            x = pend.pop_front();
            last_o = x.val;
         end
         checks++;
         if (outputs !== 8'(last_o)) begin
            errors++;
            $display("FAIL outputs cyc %0d: got %0d want %0d", cyc, outputs, last_o);
         end
      end
      rst = r; in_valid = v; inputs = in; weights = w; bias = b;
      if (r) begin
         pend.delete();
         last_o = 0;
         armed = 1;
      end else if (v) pend.push_back('{cyc + 3, e});
      cyc++;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 0);
   endtask
   initial begin
      logic [39:0] in, w;
      logic [4:0] b;
      tbl[0] = '{{8{5'd1}},  {8{5'd1}},     5'd0,  8};
      tbl[1] = '{{8{5'd1}},  {8{5'd1}},     5'h1f, 7};
      tbl[2] = '{{8{5'd31}}, {8{5'b10000}}, 5'd0,  0};
      tbl[3] = '{{8{5'd31}}, {8{5'd15}},    5'd15, 255};
      tbl[4] = '{40'd17,     40'd15,        5'd0,  255};
      tbl[5] = '{40'd17,     40'd15,        5'h1f, 254};
      tbl[6] = '{40'd1,      40'd1,         5'h1f, 0};
      tbl[7] = '{{8{5'd2}},  {{7{5'd1}}, 5'b11101}, 5'd0, 8};
      tbl[8] = '{{5'd3, 35'd0}, {5'd5, 35'd0}, 5'd1, 16};
      // reset held two cycles with in_valid high, then quiet
      tick(1, 1, {8{5'd1}}, {8{5'd1}}, 5'd0, 0);
      tick(1, 1, {8{5'd1}}, {8{5'd1}}, 5'd0, 0);
      idle(4);
      foreach (tbl[i]) begin
         tick(0, 1, tbl[i].in, tbl[i].w, tbl[i].b, tbl[i].e);
         idle(4);
      end
      // streaming with counter-like lanes, then a single-cycle gap
      in = {$urandom, $urandom};
      w  = {$urandom, $urandom};
      for (int i = 0; i < 10; i++) begin
         b = 5'($urandom);
         tick(0, 1, in + 40'(i), w, b, model(in + 40'(i), w, b));
      end
      for (int i = 0; i < 10; i++) begin
         in = {$urandom, $urandom}; w = {$urandom, $urandom}; b = 5'($urandom);
         tick(0, i != 5, in, w, b, model(in, w, b));
      end
      idle(4);
      // reset while two vectors are in flight, then one vector right after release
      tick(0, 1, {8{5'd31}}, {8{5'd15}}, 5'd15, 255);
      tick(0, 1, {8{5'd1}}, {8{5'd1}}, 5'd0, 8);
      tick(1, 0, '0, '0, 5'd0, 0);
      tick(0, 1, {8{5'd2}}, {8{5'd1}}, 5'd3, 19);
      idle(5);
      for (int i = 0; i < 300; i++) begin
         in = {$urandom, $urandom}; w = {$urandom, $urandom}; b = 5'($urandom);
         tick($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, in, w, b, model(in, w, b));
      end
      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
